reg_commit_ctrl: RTL

//  Sequences the register file's single write port. Accepts up to two in-order commits per cycle

---
 rtl/reg_commit_ctrl_pkg.sv | 12 +
 rtl/reg_commit_ctrl_fifo.sv | 47 ++++
 rtl/reg_commit_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/reg_commit_ctrl_pkg.sv
// Shared definitions for the register-file commit sequencer: ROB tag width and controller states.
package reg_commit_ctrl_pkg;

  localparam int ROB_WIDTH_BIT = 4;

  typedef enum logic [1:0] {
    RCC_IDLE  = 2'b00,
    RCC_DRAIN = 2'b01,
    RCC_CLEAR = 2'b10
  } rcc_state_e;

endpackage

// File: rtl/reg_commit_ctrl_fifo.sv
// commit_fifo: dual-push / single-pop synchronous FIFO with flow-through head when empty.
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 41
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push0,
  input  logic                   push1,
  input  logic [W-1:0]           din0,
  input  logic [W-1:0]           din1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wsel1;

  assign wsel1 = push0 ? wptr + AW'(1) : wptr;

  // An empty queue hands the oldest incoming entry straight to the reader.
  assign head = (count == '0) ? (push0 ? din0 : din1) : mem[rptr];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push0) + AW'(push1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push0) mem[wptr]  <= din0;
    if (push1) mem[wsel1] <= din1;
  end

endmodule

// File: rtl/reg_commit_ctrl.sv
// Register-file write-port sequencer: queues ROB commits, emits one write per cycle, drains then
// pulses clear_flag on flush. Optional retired-write counter under REG_COMMIT_CNT_EN.
//
// state     | meaning
// RCC_IDLE  | accepting commits, writing queued entries
// RCC_DRAIN | flush seen, retiring pre-flush writes, no new commits
// RCC_CLEAR | clear_flag high for one cycle, wr_reg already 0
module reg_commit_ctrl
  import reg_commit_ctrl_pkg::*;
#(
  parameter int ROB_W  = ROB_WIDTH_BIT,
  parameter int QDEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [1:0]       cm_valid,
  input  logic [4:0]       cm_reg0,
  input  logic [4:0]       cm_reg1,
  input  logic [ROB_W-1:0] cm_rob0,
  input  logic [ROB_W-1:0] cm_rob1,
  input  logic [31:0]      cm_val0,
  input  logic [31:0]      cm_val1,
  output logic             cm_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic [4:0]       wr_reg,
  output logic [ROB_W-1:0] wr_rob,
  output logic [31:0]      wr_val,
`ifdef REG_COMMIT_CNT_EN
  output logic [31:0]      commit_cnt,
`endif
  output logic             clear_flag
);

  localparam int W  = 5 + ROB_W + 32;
  localparam int CW = $clog2(QDEPTH) + 1;

  rcc_state_e    state_q;
  rcc_state_e    state_nxt;
  logic [CW-1:0] count;
  logic [W-1:0]  head;
  logic          push0;
  logic          push1;
  logic          pop;

  assign cm_ready = (state_q == RCC_IDLE) && (count <= CW'(QDEPTH - 2)) && rdy_in;
  assign push0    = cm_ready && cm_valid[0] && (cm_reg0 != 5'd0);
  assign push1    = cm_ready && cm_valid[0] && cm_valid[1] && (cm_reg1 != 5'd0);
  assign pop      = rdy_in && ((count != '0) || push0 || push1);

  commit_fifo #(
    .DEPTH (QDEPTH),
    .W     (W)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push0  (push0),
    .push1  (push1),
    .din0   ({cm_reg0, cm_rob0, cm_val0}),
    .din1   ({cm_reg1, cm_rob1, cm_val1}),
    .pop    (pop),
    .count  (count),
    .head   (head)
  );

  // DRAIN leaves one cycle after the last pop so the final write is not overlapped by clear_flag.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RCC_IDLE: begin
        if (flush_req)
          state_nxt = ((count == '0) && !push0 && !push1) ? RCC_CLEAR : RCC_DRAIN;
      end
      RCC_DRAIN: begin
        if (count == '0) state_nxt = RCC_CLEAR;
      end
      RCC_CLEAR: state_nxt = RCC_IDLE;
      default:   state_nxt = RCC_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state_q <= RCC_IDLE;
    else if (rdy_in) state_q <= state_nxt;
  end

  assign flush_busy = (state_q != RCC_IDLE);
  assign clear_flag = (state_q == RCC_CLEAR);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_reg <= '0;
      wr_rob <= '0;
      wr_val <= '0;
    end else if (rdy_in) begin
      if (pop) begin
        wr_reg <= head[W-1 -: 5];
        wr_rob <= head[32 +: ROB_W];
        wr_val <= head[31:0];
      end else begin
        wr_reg <= '0;
      end
    end
  end

`ifdef REG_COMMIT_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                commit_cnt <= '0;
    else if (rdy_in && pop)    commit_cnt <= commit_cnt + 32'd1;
  end
`endif

endmodule
